// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan display.
//   SEG_BLANK / SEG_DASH : active-high gfedcba patterns for a dark digit and a dash
//   seg7_decode          : BCD nibble -> active-high gfedcba (non-decimal nibbles blank)
//   conv_state_t         : state of the binary-to-BCD converter
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
//   CLK100MHZ, reset_n : system clock, asynchronous active-low reset
//   value, value_valid : binary value and load request (taken only while idle)
//   bcd                : last committed BCD digits, digit 0 in bits [3:0]
//   ovf                : last committed value did not fit in NUM_DIGITS digits
//   busy               : conversion in progress; this is the FSM state (CONV)
//
// Handshake: value is captured on a rising edge where value_valid=1 and busy=0.
// A request seen while busy=1 is dropped, not queued.
module seg7_bcd_conv
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       value,
    input  logic                    value_valid,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    busy
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    conv_state_t        state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_work_q, ovf_work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   work_sh;
    logic [DATA_W-1:0]  bin_sh;
    logic               carry_out;

    always_comb begin
        // Add-3 correction on every nibble, then one left shift of {work, bin}.
        adj = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        carry_out = adj[BCD_W-1];
        work_sh   = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_sh    = bin_q << 1;

        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    bin_d      = value;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_W'(DATA_W - 1);
                    state_d    = CONV;
                end
            end
            CONV: begin
                bin_d      = bin_sh;
                work_d     = work_sh;
                ovf_work_d = ovf_work_q | carry_out;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // Final shift: commit straight from the shifted result.
                    bcd_d   = work_sh;
                    ovf_d   = ovf_work_q | carry_out;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == CONV);

endmodule

// File: rtl/seg7_scan_display.sv
// N-digit decimal display engine for a common-anode 7-segment bus.
//   CLK100MHZ, reset_n : system clock, asynchronous active-low reset
//   value, value_valid : binary value to show and its load request
//   busy               : conversion in progress, loads ignored
//   overflow           : shown value exceeds 10^NUM_DIGITS-1 (all digits dash)
//   dp_in              : per-digit decimal point, 1=lit, digit 0 rightmost
//   SEG, AN, DP        : active-low cathodes {g..a}, anodes, decimal point
// Build option SEG7_LZ_BLANK_EN: blank leading zeros (digit 0 always shown).
// Without it every digit is shown, e.g. "0007".
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     value,
    input  logic                  value_valid,
    output logic                  busy,
    output logic                  overflow,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [6:0]            SEG,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  DP
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    ovf;

    seg7_bcd_conv #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W)
    ) u_conv (
        .CLK100MHZ   (CLK100MHZ),
        .reset_n     (reset_n),
        .value       (value),
        .value_valid (value_valid),
        .bcd         (bcd),
        .ovf         (ovf),
        .busy        (busy)
    );

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  step;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  above_zero;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  lz_sel;
    logic [6:0]            pattern;

    always_comb begin
        lead_zero  = '0;
        above_zero = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero && (bcd[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero && (i != 0);
        end
`endif
    end

    always_comb begin
        step  = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d = step ? '0 : div_q + 1'b1;

        nib_sel = 4'd0;
        dp_sel  = 1'b0;
        lz_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel = bcd[4*i +: 4];
                dp_sel  = dp_in[i];
                lz_sel  = lead_zero[i];
            end
        end

        if (ovf) begin
            pattern = SEG_DASH;
        end else if (lz_sel) begin
            pattern = SEG_BLANK;
        end else begin
            pattern = seg7_decode(nib_sel);
        end

        idx_d = idx_q;
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        // The output registers load the digit at the current index, then the
        // index advances, so the first step after reset lights digit 0.
        if (step) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = ~pattern;
            dp_d  = ~dp_sel;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign overflow = ovf;
    assign SEG      = seg_q;
    assign AN       = an_q;
    assign DP       = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with three parameterisations:
//   dut_a: 4 digits, 14-bit value   dut_b: 3 digits, 8-bit   dut_c: 3 digits, 10-bit
// All use REFRESH_DIV=4. Expected segment codes are active-low constants.
module tb_seg7_scan_display;

  localparam logic [6:0] S0    = 7'h40;
  localparam logic [6:0] S1    = 7'h79;
  localparam logic [6:0] S2    = 7'h24;
  localparam logic [6:0] S3    = 7'h30;
  localparam logic [6:0] S4    = 7'h19;
  localparam logic [6:0] S5    = 7'h12;
  localparam logic [6:0] S7    = 7'h78;
  localparam logic [6:0] S9    = 7'h10;
  localparam logic [6:0] SDASH = 7'h3F;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] SLZ   = 7'h7F;
`else
  localparam logic [6:0] SLZ   = 7'h40;
`endif

  logic clk;
  logic rst_n;

  logic [13:0] value_a;
  logic        valid_a, busy_a, ovf_a, dpo_a;
  logic [3:0]  dp_a, an_a;
  logic [6:0]  seg_a;

  logic [7:0]  value_b;
  logic        valid_b, busy_b, ovf_b, dpo_b;
  logic [2:0]  dp_b, an_b;
  logic [6:0]  seg_b;

  logic [9:0]  value_c;
  logic        valid_c, busy_c, ovf_c, dpo_c;
  logic [2:0]  dp_c, an_c;
  logic [6:0]  seg_c;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(4), .DATA_W(14), .REFRESH_DIV(4)) dut_a (
    .CLK100MHZ(clk), .reset_n(rst_n), .value(value_a), .value_valid(valid_a),
    .busy(busy_a), .overflow(ovf_a), .dp_in(dp_a), .SEG(seg_a), .AN(an_a), .DP(dpo_a)
  );

  seg7_scan_display #(.NUM_DIGITS(3), .DATA_W(8), .REFRESH_DIV(4)) dut_b (
    .CLK100MHZ(clk), .reset_n(rst_n), .value(value_b), .value_valid(valid_b),
    .busy(busy_b), .overflow(ovf_b), .dp_in(dp_b), .SEG(seg_b), .AN(an_b), .DP(dpo_b)
  );

  seg7_scan_display #(.NUM_DIGITS(3), .DATA_W(10), .REFRESH_DIV(4)) dut_c (
    .CLK100MHZ(clk), .reset_n(rst_n), .value(value_c), .value_valid(valid_c),
    .busy(busy_c), .overflow(ovf_c), .dp_in(dp_c), .SEG(seg_c), .AN(an_c), .DP(dpo_c)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cur_an(input int sel);
    case (sel)
      0:       return {4'b0, an_a};
      1:       return {5'b0, an_b};
      default: return {5'b0, an_c};
    endcase
  endfunction

  function automatic logic [6:0] cur_seg(input int sel);
    case (sel)
      0:       return seg_a;
      1:       return seg_b;
      default: return seg_c;
    endcase
  endfunction

  function automatic logic cur_dp(input int sel);
    case (sel)
      0:       return dpo_a;
      1:       return dpo_b;
      default: return dpo_c;
    endcase
  endfunction

  function automatic logic cur_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic load(input int sel, input logic [31:0] v);
    @(negedge clk);
    case (sel)
      0:       begin value_a = v[13:0]; valid_a = 1'b1; end
      1:       begin value_b = v[7:0];  valid_b = 1'b1; end
      default: begin value_c = v[9:0];  valid_c = 1'b1; end
    endcase
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_c = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (cur_busy(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val($sformatf("idle_wait%0d", sel), {31'b0, cur_busy(sel)}, 32'd0);
  endtask

  // Wait for a fresh refresh of digit d, then compare its SEG and DP.
  task automatic check_digit(input int sel, input int d, input logic [6:0] exp_seg,
                             input logic exp_dp, input string tag);
    int nd;
    int n = 0;
    logic [7:0] target;
    nd = (sel == 0) ? 4 : 3;
    target = 8'(((1 << nd) - 1) & ~(1 << d));
    while (cur_an(sel) == target && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (cur_an(sel) != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val($sformatf("%s_an%0d", tag, d), {24'b0, cur_an(sel)}, {24'b0, target});
    check_val($sformatf("%s_seg%0d", tag, d), {25'b0, cur_seg(sel)}, {25'b0, exp_seg});
    check_val($sformatf("%s_dp%0d", tag, d), {31'b0, cur_dp(sel)}, {31'b0, exp_dp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    value_a = '0; valid_a = 1'b0; dp_a = '0;
    value_b = '0; valid_b = 1'b0; dp_b = '0;
    value_c = '0; valid_c = 1'b0; dp_c = '0;

    // 1: reset values, then first step lights digit 0 with "0"
    repeat (2) @(negedge clk);
    check_val("rst_an", {28'b0, an_a}, 32'hF);
    check_val("rst_seg", {25'b0, seg_a}, 32'h7F);
    check_val("rst_dp", {31'b0, dpo_a}, 32'd1);
    check_val("rst_busy", {31'b0, busy_a}, 32'd0);
    check_val("rst_ovf", {31'b0, ovf_a}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("pre_step_an", {28'b0, an_a}, 32'hF);
    end
    @(negedge clk);
    check_val("step1_an", {28'b0, an_a}, 32'hE);
    check_val("step1_seg", {25'b0, seg_a}, {25'b0, S0});
    check_val("step1_dp", {31'b0, dpo_a}, 32'd1);
    check_val("step1_busy", {31'b0, busy_a}, 32'd0);
    repeat (6) @(negedge clk);

    // 2: 3 digits / 8 bits, 255, busy for exactly 8 cycles
    load(1, 32'd255);
    check_val("b255_busy0", {31'b0, busy_b}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_val($sformatf("b255_busy%0d", k), {31'b0, busy_b}, 32'd1);
    end
    @(negedge clk);
    check_val("b255_done", {31'b0, busy_b}, 32'd0);
    check_val("b255_ovf", {31'b0, ovf_b}, 32'd0);
    check_digit(1, 0, S5, 1'b1, "b255");
    check_digit(1, 1, S5, 1'b1, "b255");
    check_digit(1, 2, S2, 1'b1, "b255");

    // 3: load while busy is dropped
    load(0, 32'd1234);
    repeat (3) @(negedge clk);
    value_a = 14'd999;
    valid_a = 1'b1;
    check_val("a1234_busy_mid", {31'b0, busy_a}, 32'd1);
    @(negedge clk);
    valid_a = 1'b0;
    wait_idle(0);
    check_val("a1234_ovf", {31'b0, ovf_a}, 32'd0);
    check_digit(0, 0, S4, 1'b1, "a1234");
    check_digit(0, 1, S3, 1'b1, "a1234");
    check_digit(0, 2, S2, 1'b1, "a1234");
    check_digit(0, 3, S1, 1'b1, "a1234");
    load(0, 32'd999);
    wait_idle(0);
    check_digit(0, 0, S9, 1'b1, "a999");
    check_digit(0, 1, S9, 1'b1, "a999");
    check_digit(0, 2, S9, 1'b1, "a999");
    check_digit(0, 3, SLZ, 1'b1, "a999");

    // 4: overflow shows dashes, then recovers
    load(2, 32'd1000);
    wait_idle(2);
    check_val("c1000_ovf", {31'b0, ovf_c}, 32'd1);
    check_digit(2, 0, SDASH, 1'b1, "c1000");
    check_digit(2, 1, SDASH, 1'b1, "c1000");
    check_digit(2, 2, SDASH, 1'b1, "c1000");
    load(2, 32'd42);
    wait_idle(2);
    check_val("c42_ovf", {31'b0, ovf_c}, 32'd0);
    check_digit(2, 0, S2, 1'b1, "c42");
    check_digit(2, 1, S4, 1'b1, "c42");
    check_digit(2, 2, SLZ, 1'b1, "c42");

    // 5: value 7 with decimal point on digit 1
    dp_a = 4'b0010;
    load(0, 32'd7);
    wait_idle(0);
    check_digit(0, 0, S7, 1'b1, "a7");
    check_digit(0, 1, SLZ, 1'b0, "a7");
    check_digit(0, 2, SLZ, 1'b1, "a7");
    check_digit(0, 3, SLZ, 1'b1, "a7");

    // 6: asynchronous reset mid-conversion
    dp_a = 4'b0000;
    load(0, 32'd5000);
    repeat (3) @(negedge clk);
    check_val("a5000_busy", {31'b0, busy_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_an", {28'b0, an_a}, 32'hF);
    check_val("arst_seg", {25'b0, seg_a}, 32'h7F);
    check_val("arst_dp", {31'b0, dpo_a}, 32'd1);
    check_val("arst_busy", {31'b0, busy_a}, 32'd0);
    check_val("arst_ovf", {31'b0, ovf_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", {31'b0, busy_a}, 32'd0);
    check_digit(0, 0, S0, 1'b1, "post_rst");
    check_digit(0, 1, SLZ, 1'b1, "post_rst");
    check_digit(0, 3, SLZ, 1'b1, "post_rst");
    check_val("post_rst_busy_end", {31'b0, busy_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
